cache_cmd_sequencer: RTL and testbench

Upstream feeder for the LLC cache model. It buffers trace commands (opcode n plus 32-bit address) from the trace reader in a FIFO. It drops illegal opcodes. It issues commands to the cache one at a time as a single-cycle valid pulse, then waits for the cache's operation-finished indication before issuing the next. A watchdog recovers if the cache never finishes.

---
 rtl/cache_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cache_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cache_cmd_sequencer
// Purpose  : Buffers trace commands in a FIFO, drops illegal opcodes and issues
//            them one at a time to the LLC cache model, with a done watchdog.
//            Optional per-class issue statistics: define CACHE_CMD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_cmd_sequencer #(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_n,
    input  logic [31:0]      cmd_addr,
    output logic             cache_valid,
    output logic [3:0]       cache_n,
    output logic [31:0]      cache_addr,
    input  logic             cache_done,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] dropped_cnt
`ifdef CACHE_CMD_STATS_EN
    ,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] snoop_cnt
`endif
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [35:0]       r_mem [DEPTH];
    logic [3:0]        r_cache_n;
    logic [31:0]       r_cache_addr;
    logic [WD_W-1:0]   r_wdog;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_dropped;

    logic w_full, w_empty, w_legal, w_accept, w_push, w_drop;
    logic w_pop, w_issue, w_timeout, w_wdog_last;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_legal  = (cmd_n <= 4'd6) || (cmd_n == 4'd8) || (cmd_n == 4'd9);
    assign w_accept = cmd_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_drop   = w_accept && !w_legal;

    // Post-increment watchdog value would reach TIMEOUT-1 on this cycle.
    assign w_wdog_last = (r_wdog == WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_issue   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (cache_done) begin
                    w_next = S_IDLE;
                end else if (w_wdog_last) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {cmd_n, cmd_addr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cache_n     <= '0;
            r_cache_addr  <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
            r_issued      <= '0;
            r_dropped     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
                {r_cache_n, r_cache_addr} <= r_mem[r_rd_ptr[PTR_W-1:0]];
            end
            if (w_issue)                           r_wdog <= '0;
            else if (r_state == S_WAIT && !cache_done) r_wdog <= r_wdog + 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_issue && r_issued != '1)  r_issued  <= r_issued + CNT_W'(1);
            if (w_drop && r_dropped != '1)  r_dropped <= r_dropped + CNT_W'(1);
        end
    end

`ifdef CACHE_CMD_STATS_EN
    logic [CNT_W-1:0] r_rd_cnt, r_wr_cnt, r_snoop_cnt;
    logic w_is_rd, w_is_wr, w_is_snoop;

    assign w_is_rd    = (r_cache_n == 4'd0) || (r_cache_n == 4'd2);
    assign w_is_wr    = (r_cache_n == 4'd1);
    assign w_is_snoop = (r_cache_n >= 4'd3) && (r_cache_n <= 4'd6);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_snoop_cnt <= '0;
        end else if (w_issue) begin
            if (w_is_rd && r_rd_cnt != '1)       r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
            if (w_is_wr && r_wr_cnt != '1)       r_wr_cnt    <= r_wr_cnt + CNT_W'(1);
            if (w_is_snoop && r_snoop_cnt != '1) r_snoop_cnt <= r_snoop_cnt + CNT_W'(1);
        end
    end

    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;
    assign snoop_cnt = r_snoop_cnt;
`endif

    assign cmd_ready   = !w_full;
    assign cache_valid = (r_state == S_ISSUE);
    assign cache_n     = r_cache_n;
    assign cache_addr  = r_cache_addr;
    assign busy        = !w_empty || (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;
    assign issued_cnt  = r_issued;
    assign dropped_cnt = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_cache_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_cmd_sequencer
// Purpose  : Directed bench with an issue scoreboard for cache_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_cmd_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_n = '0;
    logic [31:0]      cmd_addr = '0;
    logic             cache_valid;
    logic [3:0]       cache_n;
    logic [31:0]      cache_addr;
    logic             cache_done = 1'b0;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] dropped_cnt;
`ifdef CACHE_CMD_STATS_EN
    logic [CNT_W-1:0] rd_cnt, wr_cnt, snoop_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [35:0] exp_q[$];

    cache_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_n      (cmd_n),
        .cmd_addr   (cmd_addr),
        .cache_valid(cache_valid),
        .cache_n    (cache_n),
        .cache_addr (cache_addr),
        .cache_done (cache_done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .issued_cnt (issued_cnt),
        .dropped_cnt(dropped_cnt)
`ifdef CACHE_CMD_STATS_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .snoop_cnt  (snoop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal_op(input logic [3:0] n);
        return (n <= 4'd6) || (n == 4'd8) || (n == 4'd9);
    endfunction

    // Offer one command for one cycle; legal ones are expected at the cache later.
    task automatic push(input logic [3:0] n, input logic [31:0] a);
        cmd_valid = 1'b1;
        cmd_n     = n;
        cmd_addr  = a;
        if (legal_op(n) && cmd_ready) exp_q.push_back({n, a});
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(input int budget);
        int k = 0;
        while (cache_valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("issue_wait", cache_valid, 1);
    endtask

    // Issue observed, then one WAIT cycle, then done; ends in the IDLE cycle.
    task automatic serve_one();
        wait_issue(20);
        step();
        cache_done = 1'b1;
        step();
        cache_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    // Scoreboard: every issue strobe must match the oldest legal push.
    always @(negedge clk) begin
        if (!rst && cache_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {cache_n, cache_addr}, 0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("issue_n", cache_n, e[35:32]);
                chk("issue_addr", cache_addr, e[31:0]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_cache_valid", cache_valid, 0);
        chk("rst_cache_n", cache_n, 0);
        chk("rst_cache_addr", cache_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_dropped", dropped_cnt, 0);

        // Single command: issue two cycles after push, fields stable until done
        push(4'd0, 32'h0000_1A40);
        chk("single_no_early_valid", cache_valid, 0);
        chk("single_busy", busy, 1);
        step();
        chk("single_valid_t2", cache_valid, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_valid_once", cache_valid, 0);
            chk("single_n_stable", cache_n, 0);
            chk("single_addr_stable", cache_addr, 32'h0000_1A40);
        end
        step();
        cache_done = 1'b1;
        chk("single_busy_at_done", busy, 1);
        step();
        cache_done = 1'b0;
        chk("single_busy_after_done", busy, 0);
        chk("single_issued", issued_cnt, 1);

        // Fill: one in flight plus DEPTH queued makes the FIFO full
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == DEPTH) chk("fill_ready_before_last", cmd_ready, 1);
            push(4'(i % 7), 32'h1000_0000 + 32'(i * 16));
        end
        chk("fill_ready_full", cmd_ready, 0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            cache_done = 1'b1;
            step();
            if (i == 3) begin
                // done held through IDLE and ISSUE must not end the next command
                chk("drain_idle_gap", cache_valid, 0);
                step();
                chk("drain_issue_2_after_done", cache_valid, 1);
                cache_done = 1'b0;
                step();
                step();
                chk("done_in_issue_ignored", cache_valid, 0);
                chk("done_in_issue_busy", busy, 1);
            end else begin
                cache_done = 1'b0;
                if (i < DEPTH) begin
                    chk("drain_idle_gap", cache_valid, 0);
                    step();
                    chk("drain_issue_2_after_done", cache_valid, 1);
                    step();
                end else begin
                    chk("drain_done_busy", busy, 0);
                end
            end
        end
        chk("fill_issued", issued_cnt, 10);
        chk("fill_queue_empty", exp_q.size(), 0);

        // Illegal opcodes dropped
        push(4'd7, 32'hDEAD_0007);
        push(4'd12, 32'hDEAD_000C);
        push(4'd1, 32'h0000_2B80);
        chk("drop_cnt", dropped_cnt, 2);
        serve_one();
        chk("drop_issued", issued_cnt, 11);

        // Watchdog expiry, then the next queued command issues
        push(4'd3, 32'h0000_3000);
        push(4'd4, 32'h0000_4000);
        wait_issue(20);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("wdog_not_yet", timeout_err, 0);
        step();
        chk("wdog_expired", timeout_err, 1);
        cache_done = 1'b1;
        step();
        cache_done = 1'b0;
        chk("wdog_next_issue", cache_valid, 1);
        step();
        step();
        chk("late_done_ignored", busy, 1);
        cache_done = 1'b1;
        step();
        cache_done = 1'b0;
        chk("wdog_sticky", timeout_err, 1);
        chk("wdog_issued", issued_cnt, 13);

        // Mid-operation reset with three entries queued
        push(4'd5, 32'h5555_0000);
        push(4'd2, 32'h5555_0010);
        push(4'd6, 32'h5555_0020);
        push(4'd9, 32'h5555_0030);
        chk("midrst_in_flight", busy, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_cache_n", cache_n, 0);
        chk("midrst_cache_addr", cache_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_issued", issued_cnt, 0);
        chk("midrst_dropped", dropped_cnt, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("midrst_no_issue", issued_cnt, 0);
        chk("midrst_idle", busy, 0);
        push(4'd8, 32'h0000_8888);
        serve_one();
        chk("midrst_new_issue", issued_cnt, 1);

`ifdef CACHE_CMD_STATS_EN
        do_reset();
        push(4'd0, 32'h0000_0100);
        push(4'd1, 32'h0000_0200);
        push(4'd2, 32'h0000_0300);
        push(4'd4, 32'h0000_0400);
        push(4'd8, 32'h0000_0500);
        for (int i = 0; i < 5; i++) serve_one();
        chk("stats_rd", rd_cnt, 2);
        chk("stats_wr", wr_cnt, 1);
        chk("stats_snoop", snoop_cnt, 1);
        chk("stats_issued", issued_cnt, 5);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
